digit_counter_ctrl: RTL

//   Upstream source for the 7-segment decoder on HEX0: a single-digit up/down counter driven by
//   one DE10-Lite push-button (start/pause) plus direction and clear switches. It produces the
//   4-bit code the decoder consumes: 0-9 for the digit, 10 (4'b1010) as the idle "dash" code.

---
 rtl/digit_counter_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/digit_counter_ctrl.sv
// Single-digit up/down counter feeding the HEX0 7-segment decoder.
// One push-button starts and pauses counting. The dir switch sets the count
// direction and the clr switch returns the counter to the idle dash code (10).
module digit_counter_ctrl #(
    parameter int unsigned CLK_DIV   = 50_000_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       dir,
    input  logic       clr,
    output logic [3:0] code,
    output logic       running
);

    localparam int unsigned PW = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [3:0]    CODE_DASH  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } state_t;

    logic          key_meta_q, key_sync_q;
    logic          dir_meta_q, dir_sync_q;
    logic          clr_meta_q, clr_sync_q;

    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          db_level_q, db_level_d;
    logic          db_prev_q;
    logic          press_q;

    state_t        state_q;
    logic [3:0]    code_q;
    logic          running_q;
    logic [PW-1:0] presc_q;

    logic          tick;
    logic [3:0]    step_code;

    // Two-flop synchronizers for the asynchronous switch and button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            dir_meta_q <= 1'b0;
            dir_sync_q <= 1'b0;
            clr_meta_q <= 1'b0;
            clr_sync_q <= 1'b0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            dir_meta_q <= dir;
            dir_sync_q <= dir_meta_q;
            clr_meta_q <= clr;
            clr_sync_q <= clr_meta_q;
        end
    end

    // Debounce: the new level is accepted after DB_CYCLES consecutive differing samples.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        if (key_sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = key_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and the registered press pulse, raised one cycle after the level falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b1;
            db_prev_q  <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
            press_q    <= db_prev_q & ~db_level_q;
        end
    end

    // Count-rate tick and the next digit in the selected direction.
    always_comb begin
        tick = (presc_q == PRESC_LAST);
        if (dir_sync_q) begin
            step_code = (code_q == 4'd9) ? 4'd0 : code_q + 4'd1;
        end else begin
            step_code = (code_q == 4'd0) ? 4'd9 : code_q - 4'd1;
        end
    end

    // Control FSM with registered outputs. Priority is clear, then press, then tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= CODE_DASH;
            running_q <= 1'b0;
            presc_q   <= '0;
        end else if (clr_sync_q) begin
            state_q   <= ST_IDLE;
            code_q    <= CODE_DASH;
            running_q <= 1'b0;
            presc_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_q <= '0;
                    if (press_q) begin
                        state_q   <= ST_RUN;
                        code_q    <= 4'd0;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (press_q) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                        presc_q   <= '0;
                    end else if (tick) begin
                        code_q  <= step_code;
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    presc_q <= '0;
                    if (press_q) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    code_q    <= CODE_DASH;
                    running_q <= 1'b0;
                    presc_q   <= '0;
                end
            endcase
        end
    end

    assign code    = code_q;
    assign running = running_q;

endmodule
